// File: rtl/jtag_uart_pkg.sv
// rtl/jtag_uart_pkg.sv - shared constants and FSM encoding for the JTAG UART controller
package jtag_uart_pkg;
  localparam int DR_W    = 10;
  localparam int CAP_TXP = 9;
  localparam int CAP_RXF = 8;
  localparam int UPD_WR  = 9;
  localparam int UPD_ACK = 8;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    SHIFT,
    COMMIT
  } state_t;
endpackage

// File: rtl/jtag_sync.sv
// rtl/jtag_sync.sv - multi-flop 1-bit synchronizer for TAP inputs into sys_clk
module jtag_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/jtag_uart_ctrl.sv
// rtl/jtag_uart_ctrl.sv - user-chain DR sequencer exposing a one-byte tx/rx link to sys_clk
module jtag_uart_ctrl
  import jtag_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       jtag_tck,
  input  logic       jtag_tdi,
  output logic       jtag_tdo,
  input  logic       jtag_shift,
  input  logic       jtag_update,
  input  logic       jtag_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overflow
);
  logic [4:0] tap_in;
  logic [4:0] tap_s;
  logic       tck_s, tdi_s, shift_s, update_s, treset_s;
  logic       tck_h, shift_h, update_h;
  logic       tck_rise, tck_fall, shift_rise, shift_fall, update_rise;

  state_t          state, state_nxt;
  logic [DR_W-1:0] sr;
  logic [DR_W-1:0] cap_word;
  logic [7:0]      tx_buf;
  logic            tx_pend;
  logic            commit;

  // Identical sync depth on every TAP input keeps their relative ordering intact.
  assign tap_in = {jtag_reset, jtag_update, jtag_shift, jtag_tdi, jtag_tck};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    jtag_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (sys_clk),
      .rst (sys_rst),
      .d   (tap_in[i]),
      .q   (tap_s[i])
    );
  end

  assign {treset_s, update_s, shift_s, tdi_s, tck_s} = tap_s;

  assign tck_rise    = tck_s & ~tck_h;
  assign tck_fall    = ~tck_s & tck_h;
  assign shift_rise  = shift_s & ~shift_h;
  assign shift_fall  = ~shift_s & shift_h;
  assign update_rise = update_s & ~update_h;

  assign cap_word = {tx_pend, rx_valid, tx_buf};
  assign commit   = (state == COMMIT) && !treset_s;
  assign tx_ready = ~tx_pend;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (treset_s) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (shift_rise)       state_nxt = CAPT;
          else if (update_rise) state_nxt = COMMIT;
        end
        CAPT:    state_nxt = SHIFT;
        SHIFT:   if (shift_fall) state_nxt = IDLE;
        COMMIT:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tck_h    <= 1'b0;
      shift_h  <= 1'b0;
      update_h <= 1'b0;
      sr       <= '0;
      jtag_tdo <= 1'b0;
    end else begin
      tck_h    <= tck_s;
      shift_h  <= shift_s;
      update_h <= update_s;
      if (treset_s) begin
        sr       <= '0;
        jtag_tdo <= 1'b0;
      end else if (state == CAPT) begin
        sr       <= cap_word;
        jtag_tdo <= cap_word[0];
      end else if (state == SHIFT) begin
        if (tck_rise) sr       <= {tdi_s, sr[DR_W-1:1]};
        if (tck_fall) jtag_tdo <= sr[0];
      end
    end
  end

  // A host ack only matters while a byte is pending, so a same-cycle accept never collides with it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_buf      <= '0;
      tx_pend     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (tx_valid && !tx_pend) begin
        tx_buf  <= tx_data;
        tx_pend <= 1'b1;
      end else if (commit && sr[UPD_ACK]) begin
        tx_pend <= 1'b0;
      end

      if (commit && sr[UPD_WR]) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= sr[7:0];
          rx_valid <= 1'b1;
        end else begin
          rx_overflow <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jtag_uart_ctrl.sv
// tb/tb_jtag_uart_ctrl.sv - directed and randomized host-scan bench for jtag_uart_ctrl
module tb_jtag_uart_ctrl;
  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       jtag_tck, jtag_tdi, jtag_tdo, jtag_shift, jtag_update, jtag_reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_overflow;

  int checks   = 0;
  int failures = 0;

  jtag_uart_ctrl #(.SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .jtag_tck    (jtag_tck),
    .jtag_tdi    (jtag_tdi),
    .jtag_tdo    (jtag_tdo),
    .jtag_shift  (jtag_shift),
    .jtag_update (jtag_update),
    .jtag_reset  (jtag_reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overflow (rx_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(posedge sys_clk); #1;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge sys_clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic pulse_rx_ready();
    @(posedge sys_clk); #1;
    rx_ready = 1'b1;
    @(posedge sys_clk); #1;
    rx_ready = 1'b0;
  endtask

  // Host scan: TCK half period is two sys_clk cycles at a random phase; tdo is
  // sampled at the end of each high phase, update pulse follows shift release.
  task automatic scan(input logic [9:0] din, input bit rdy_commit, output logic [9:0] cap);
    int ph;
    ph = $urandom_range(1, 8);
    @(posedge sys_clk); #(ph);
    jtag_shift = 1'b1;
    #50;
    for (int k = 0; k < 10; k++) begin
      jtag_tdi = din[k];
      #20 jtag_tck = 1'b1;
      #20 cap[k] = jtag_tdo;
      jtag_tck = 1'b0;
    end
    #20 jtag_shift = 1'b0;
    #40 jtag_update = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 if (rdy_commit) rx_ready = 1'b1;
    @(posedge sys_clk);
    #1 rx_ready = 1'b0;
    jtag_update = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
  endtask

  logic [9:0] cap;
  bit         m_txp, m_rxv, m_ovf;
  logic [7:0] m_txb, m_rxd;
  logic       wr, ack;
  logic [7:0] byt;

  initial begin
    sys_rst = 1'b1;
    {jtag_tck, jtag_tdi, jtag_shift, jtag_update, jtag_reset} = '0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    #23;
    check("rst_tdo", 16'(jtag_tdo), 16'h0);
    check("rst_tx_ready", 16'(tx_ready), 16'h1);
    check("rst_rx_valid", 16'(rx_valid), 16'h0);
    check("rst_rx_data", 16'(rx_data), 16'h0);
    check("rst_overflow", 16'(rx_overflow), 16'h0);
    @(posedge sys_clk); #3 sys_rst = 1'b0;

    // TX path: capture carries the pending byte until the host acks it
    push_tx(8'hA5);
    check("tx_ready_after_accept", 16'(tx_ready), 16'h0);
    scan(10'h000, 1'b0, cap);
    check("tx_capture_a5", 16'(cap), 16'h2A5);
    check("tx_still_pending", 16'(tx_ready), 16'h0);
    scan(10'h100, 1'b0, cap);
    check("tx_capture_again", 16'(cap), 16'h2A5);
    check("tx_ready_after_ack", 16'(tx_ready), 16'h1);

    // RX path
    scan(10'h23C, 1'b0, cap);
    check("rx_capture_empty", 16'(cap), 16'h0A5);
    check("rx_valid_after_wr", 16'(rx_valid), 16'h1);
    check("rx_data_3c", 16'(rx_data), 16'h3C);
    scan(10'h000, 1'b0, cap);
    check("rx_capture_full_flag", 16'(cap), 16'h1A5);
    pulse_rx_ready();
    check("rx_valid_after_consume", 16'(rx_valid), 16'h0);

    // Overflow, then write landing in the same cycle as a consume
    scan(10'h23C, 1'b0, cap);
    scan(10'h255, 1'b0, cap);
    check("ovf_rx_data_kept", 16'(rx_data), 16'h3C);
    check("ovf_flag", 16'(rx_overflow), 16'h1);
    check("ovf_rx_valid", 16'(rx_valid), 16'h1);
    scan(10'h255, 1'b1, cap);
    check("commit_consume_data", 16'(rx_data), 16'h55);
    check("commit_consume_valid", 16'(rx_valid), 16'h1);
    check("ovf_sticky", 16'(rx_overflow), 16'h1);

    // sys_rst asserted mid-cycle with state loaded
    push_tx(8'h11);
    @(posedge sys_clk); #4 sys_rst = 1'b1;
    #1;
    check("midrst_tdo", 16'(jtag_tdo), 16'h0);
    check("midrst_tx_ready", 16'(tx_ready), 16'h1);
    check("midrst_rx_valid", 16'(rx_valid), 16'h0);
    check("midrst_rx_data", 16'(rx_data), 16'h0);
    check("midrst_overflow", 16'(rx_overflow), 16'h0);
    #20 sys_rst = 1'b0;

    // TAP reset after 4 tck pulses of a scan
    push_tx(8'h5A);
    @(posedge sys_clk); #3;
    jtag_shift = 1'b1;
    #50;
    for (int k = 0; k < 4; k++) begin
      jtag_tdi = 1'b1;
      #20 jtag_tck = 1'b1;
      #20 jtag_tck = 1'b0;
    end
    #40;
    check("treset_pre_tdo", 16'(jtag_tdo), 16'h1);
    jtag_reset = 1'b1;
    #60;
    check("treset_tdo", 16'(jtag_tdo), 16'h0);
    jtag_shift = 1'b0;
    #40 jtag_update = 1'b1;
    #40 jtag_update = 1'b0;
    #40 jtag_reset = 1'b0;
    #60;
    check("treset_tx_pend_kept", 16'(tx_ready), 16'h0);
    check("treset_rx_untouched", 16'({rx_valid, rx_overflow}), 16'h0);
    scan(10'h100, 1'b0, cap);
    check("treset_next_capture", 16'(cap), 16'h25A);
    check("treset_ack_clears", 16'(tx_ready), 16'h1);

    // Randomized scans against a transaction-level model
    m_txp = 1'b0; m_txb = 8'h5A; m_rxv = 1'b0; m_rxd = 8'h00; m_ovf = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (!m_txp && $urandom_range(0, 1) == 1) begin
        byt = 8'($urandom);
        push_tx(byt);
        m_txp = 1'b1;
        m_txb = byt;
      end
      if (m_rxv && $urandom_range(0, 2) == 0) begin
        check($sformatf("rand_consume_%0d", n), 16'(rx_data), 16'(m_rxd));
        pulse_rx_ready();
        m_rxv = 1'b0;
      end
      wr  = 1'($urandom);
      ack = 1'($urandom);
      byt = 8'($urandom);
      scan({wr, ack, byt}, 1'b0, cap);
      check($sformatf("rand_capture_%0d", n), 16'(cap), 16'({m_txp, m_rxv, m_txb}));
      if (ack) m_txp = 1'b0;
      if (wr) begin
        if (!m_rxv) begin
          m_rxd = byt;
          m_rxv = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      check($sformatf("rand_state_%0d", n), 16'({tx_ready, rx_valid, rx_overflow, rx_data}),
            16'({~m_txp, m_rxv, m_ovf, m_rxd}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
